// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle RV32I core: owns PC and IR and runs one
// req/gnt/rvalid read on imem per fetch_start, reporting misalign/bus-error/timeout faults.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  input  logic        pc_inc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req is held while in REQ and the request is accepted on the
  // cycle imem_gnt is seen high; imem_rvalid is only honoured in WAIT, and
  // imem_err is meaningful only together with imem_rvalid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS   = 2'b10;
  localparam logic [1:0] CAUSE_TMO   = 2'b11;

  state_e      state, state_d;
  logic [7:0]  timer;
  logic        addr_load, ir_load, cause_load, timer_clr, timer_inc;
  logic [1:0]  cause_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    addr_load  = 1'b0;
    ir_load    = 1'b0;
    cause_load = 1'b0;
    cause_d    = CAUSE_NONE;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_start) begin
          cause_load = 1'b1;
          if (pc[1:0] != 2'b00) begin
            cause_d = CAUSE_ALIGN;
            state_d = DONE;
          end else begin
            addr_load = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (imem_gnt) begin
          timer_clr = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // A response on the final timer cycle still wins over the timeout.
        if (imem_rvalid) begin
          if (imem_err) begin
            cause_load = 1'b1;
            cause_d    = CAUSE_BUS;
          end else begin
            ir_load = 1'b1;
          end
          state_d = DONE;
        end else if (timer == TIMEOUT_LAST) begin
          cause_load = 1'b1;
          cause_d    = CAUSE_TMO;
          state_d    = DONE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr   <= '0;
      instr       <= NOP_INSTR;
      fault_cause <= CAUSE_NONE;
      timer       <= '0;
    end else begin
      if (addr_load)  imem_addr   <= pc;
      if (ir_load)    instr       <= imem_rdata;
      if (cause_load) fault_cause <= cause_d;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 8'd1;
    end
  end

  // PC runs independently of the FSM; the bus uses the latched imem_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_inc)  pc <= pc_plus4;
  end

  assign pc_plus4    = pc + 32'd4;
  assign opcode      = instr[6:0];
  assign imem_req    = (state == REQ);
  assign fetch_busy  = (state == REQ) || (state == WAIT);
  assign fetch_done  = (state == DONE);
  assign fetch_fault = (state == DONE) && (fault_cause != CAUSE_NONE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: expected IR words and fault causes are queued when a
// fetch is launched and popped when fetch_done is observed.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_start, pc_load, pc_inc;
  logic [31:0] pc_load_val;
  logic        imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, pc_plus4, instr;
  logic [6:0]  opcode;
  logic        fetch_busy, fetch_done, fetch_fault;
  logic [1:0]  fault_cause, dbg_state;

  logic [31:0] exp_q[$];
  logic [1:0]  exp_cause_q[$];

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] model_pc;
  logic [31:0] model_ir;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .pc_inc(pc_inc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .pc(pc), .pc_plus4(pc_plus4),
    .instr(instr), .opcode(opcode), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish before 2ms");
    $fatal(1);
  end

  // Driver tasks
  task automatic drive_pc_load(input logic [31:0] val, input logic also_inc);
    pc_load = 1'b1; pc_load_val = val; pc_inc = also_inc;
    @(posedge clk); #1;
    pc_load = 1'b0; pc_inc = 1'b0;
    model_pc = val;
  endtask

  task automatic drive_pc_inc();
    pc_inc = 1'b1;
    @(posedge clk); #1;
    pc_inc = 1'b0;
    model_pc = model_pc + 32'd4;
  endtask

  // Launches one fetch from IDLE and plays the imem slave until fetch_done.
  task automatic run_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic err, input bit give_rv, input bit restart,
                           input bit noise, output bit got_done, output int lat,
                           output bit req_seen, output bit addr_moved,
                           output logic [31:0] addr0, output logic [31:0] o_instr,
                           output logic o_fault, output logic [1:0] o_cause);
    int cyc, req_cnt, gnt_cyc;
    bit gnt_given;
    got_done = 0; lat = 0; req_seen = 0; addr_moved = 0; addr0 = '0;
    o_instr = '0; o_fault = 1'b0; o_cause = 2'b00;
    req_cnt = 0; gnt_cyc = 0; gnt_given = 0;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    cyc = 1;
    while (cyc < 400 && !got_done) begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = $urandom;
      if (fetch_done) begin
        got_done = 1; lat = cyc; o_instr = instr; o_fault = fetch_fault; o_cause = fault_cause;
      end else begin
        if (imem_req) begin
          if (!req_seen) addr0 = imem_addr;
          else if (imem_addr !== addr0) addr_moved = 1;
          req_seen = 1;
          if (req_cnt == gnt_dly) begin
            imem_gnt = 1'b1; gnt_given = 1; gnt_cyc = cyc;
          end else if (noise) begin
            imem_rvalid = 1'b1; imem_err = 1'b1;
          end
          req_cnt++;
        end
        if (restart && cyc == 1) fetch_start = 1'b1;
        if (give_rv && gnt_given && cyc == gnt_cyc + rv_dly) begin
          imem_rvalid = 1'b1; imem_rdata = rdata; imem_err = err;
        end
        @(posedge clk); #1;
        fetch_start = 1'b0;
        cyc++;
      end
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total_cnt++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h required %h", pc, 32'h0); else pass_cnt++;
    total_cnt++; if (instr !== NOP_INSTR) $display("FAIL reset_instr: got %h required %h", instr, NOP_INSTR); else pass_cnt++;
    total_cnt++; if (opcode !== 7'h13) $display("FAIL reset_opcode: got %h required 13", opcode); else pass_cnt++;
    total_cnt++; if ({imem_req, fetch_done, fetch_busy, fetch_fault} !== 4'b0000)
      $display("FAIL reset_flags: got %b required 0000", {imem_req, fetch_done, fetch_busy, fetch_fault}); else pass_cnt++;
    total_cnt++; if ({imem_addr, fault_cause, dbg_state} !== 36'h0)
      $display("FAIL reset_addr_cause_state: got %h required 0", {imem_addr, fault_cause, dbg_state}); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_pc = 32'h0; model_ir = NOP_INSTR;
  endtask

  task automatic test_basic_fetch();
    bit done, rs, mv; int lat; logic [31:0] a0, ir; logic flt; logic [1:0] cs;
    drive_pc_load(32'h0000_0100, 1'b0);
    total_cnt++; if (pc_plus4 !== 32'h104) $display("FAIL pc_plus4: got %h required 00000104", pc_plus4); else pass_cnt++;
    exp_q.push_back(32'h0050_0093); exp_cause_q.push_back(2'b00);
    run_fetch(0, 1, 32'h0050_0093, 1'b0, 1, 0, 0, done, lat, rs, mv, a0, ir, flt, cs);
    model_ir = exp_q.pop_front();
    total_cnt++; if (!done || lat != 3) $display("FAIL basic_latency: got done=%0d lat=%0d required done=1 lat=3", done, lat); else pass_cnt++;
    total_cnt++; if (a0 !== 32'h100) $display("FAIL basic_addr: got %h required 00000100", a0); else pass_cnt++;
    total_cnt++; if (ir !== model_ir) $display("FAIL basic_instr: got %h required %h", ir, model_ir); else pass_cnt++;
    total_cnt++; if ({flt, cs} !== {1'b0, exp_cause_q.pop_front()}) $display("FAIL basic_fault: got %b%b required 000", flt, cs); else pass_cnt++;
    total_cnt++; if (opcode !== 7'h13) $display("FAIL basic_opcode: got %h required 13", opcode); else pass_cnt++;
  endtask

  task automatic test_gnt_stall();
    bit done, rs, mv; int lat; logic [31:0] a0, ir; logic flt; logic [1:0] cs;
    drive_pc_inc();
    exp_q.push_back(32'h0000_006F); exp_cause_q.push_back(2'b00);
    // Stall grant 5 cycles with stray rvalid and a second fetch_start during REQ.
    run_fetch(5, 1, 32'h0000_006F, 1'b0, 1, 1, 1, done, lat, rs, mv, a0, ir, flt, cs);
    model_ir = exp_q.pop_front();
    total_cnt++; if (!done || lat != 8) $display("FAIL stall_latency: got done=%0d lat=%0d required done=1 lat=8", done, lat); else pass_cnt++;
    total_cnt++; if (mv || a0 !== model_pc) $display("FAIL stall_addr: got %h moved=%0d required %h moved=0", a0, mv, model_pc); else pass_cnt++;
    total_cnt++; if (ir !== model_ir || flt !== 1'b0 || cs !== exp_cause_q.pop_front())
      $display("FAIL stall_result: got %h/%b/%b required %h/0/00", ir, flt, cs, model_ir); else pass_cnt++;
    total_cnt++; if (opcode !== 7'h6F) $display("FAIL stall_opcode: got %h required 6f", opcode); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({fetch_busy, fetch_done, dbg_state} !== 4'b0000)
      $display("FAIL no_queued_start: got %b required 0000", {fetch_busy, fetch_done, dbg_state}); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    bit done, rs, mv; int lat; logic [31:0] a0, ir; logic flt; logic [1:0] cs;
    drive_pc_load(32'h0000_0102, 1'b0);
    exp_q.push_back(model_ir); exp_cause_q.push_back(2'b01);
    run_fetch(0, 1, 32'h1234_5678, 1'b0, 1, 0, 0, done, lat, rs, mv, a0, ir, flt, cs);
    total_cnt++; if (!done || lat != 1 || rs) $display("FAIL misalign_timing: got done=%0d lat=%0d req=%0d required 1/1/0", done, lat, rs); else pass_cnt++;
    total_cnt++; if (ir !== exp_q.pop_front()) $display("FAIL misalign_instr: got %h required %h", ir, model_ir); else pass_cnt++;
    total_cnt++; if ({flt, cs} !== {1'b1, exp_cause_q.pop_front()}) $display("FAIL misalign_cause: got %b%b required 101", flt, cs); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({fetch_done, fetch_fault, fault_cause} !== 4'b0001)
      $display("FAIL cause_held: got %b required 0001", {fetch_done, fetch_fault, fault_cause}); else pass_cnt++;
  endtask

  task automatic test_bus_error();
    bit done, rs, mv; int lat; logic [31:0] a0, ir; logic flt; logic [1:0] cs;
    drive_pc_load(32'h0000_0200, 1'b0);
    exp_q.push_back(model_ir); exp_cause_q.push_back(2'b10);
    run_fetch(1, 2, 32'hDEAD_BEEF, 1'b1, 1, 0, 0, done, lat, rs, mv, a0, ir, flt, cs);
    total_cnt++; if (!done || lat != 5) $display("FAIL buserr_latency: got done=%0d lat=%0d required 1/5", done, lat); else pass_cnt++;
    total_cnt++; if (ir !== exp_q.pop_front()) $display("FAIL buserr_instr: got %h required %h", ir, model_ir); else pass_cnt++;
    total_cnt++; if ({flt, cs} !== {1'b1, exp_cause_q.pop_front()}) $display("FAIL buserr_cause: got %b%b required 110", flt, cs); else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit done, rs, mv; int lat; logic [31:0] a0, ir; logic flt; logic [1:0] cs;
    drive_pc_inc();
    exp_q.push_back(model_ir); exp_cause_q.push_back(2'b11);
    run_fetch(0, 1, 32'h0, 1'b0, 0, 0, 0, done, lat, rs, mv, a0, ir, flt, cs);
    total_cnt++; if (!done || lat != 6) $display("FAIL timeout_latency: got done=%0d lat=%0d required 1/6", done, lat); else pass_cnt++;
    total_cnt++; if (ir !== exp_q.pop_front() || {flt, cs} !== {1'b1, exp_cause_q.pop_front()})
      $display("FAIL timeout_result: got %h/%b%b required %h/111", ir, flt, cs, model_ir); else pass_cnt++;
    // Response on the last permitted WAIT cycle must still be accepted.
    drive_pc_inc();
    exp_q.push_back(32'h0010_0113); exp_cause_q.push_back(2'b00);
    run_fetch(0, 4, 32'h0010_0113, 1'b0, 1, 0, 0, done, lat, rs, mv, a0, ir, flt, cs);
    model_ir = exp_q.pop_front();
    total_cnt++; if (!done || lat != 6 || ir !== model_ir || {flt, cs} !== {1'b0, exp_cause_q.pop_front()})
      $display("FAIL last_cycle_rvalid: got lat=%0d %h/%b%b required lat=6 %h/000", lat, ir, flt, cs, model_ir); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit done, rs, mv; int lat, gd, rd; logic [31:0] a0, ir, data; logic flt; logic [1:0] cs;
    for (int i = 0; i < 6; i++) begin
      drive_pc_inc();
      gd = $urandom_range(0, 3); rd = $urandom_range(1, 4); data = $urandom;
      exp_q.push_back(data); exp_cause_q.push_back(2'b00);
      run_fetch(gd, rd, data, 1'b0, 1, 0, 0, done, lat, rs, mv, a0, ir, flt, cs);
      model_ir = exp_q.pop_front();
      total_cnt++; if (!done || lat != 2 + gd + rd || a0 !== model_pc)
        $display("FAIL b2b_%0d_timing: got lat=%0d addr=%h required lat=%0d addr=%h", i, lat, a0, 2 + gd + rd, model_pc); else pass_cnt++;
      total_cnt++; if (ir !== model_ir || {flt, cs} !== {1'b0, exp_cause_q.pop_front()} || opcode !== model_ir[6:0])
        $display("FAIL b2b_%0d_data: got %h/%b%b required %h/000", i, ir, flt, cs, model_ir); else pass_cnt++;
    end
  endtask

  task automatic test_pc_update();
    drive_pc_load(32'hFFFF_FFFC, 1'b0);
    total_cnt++; if (pc_plus4 !== 32'h0) $display("FAIL pc_plus4_wrap: got %h required 00000000", pc_plus4); else pass_cnt++;
    drive_pc_inc();
    total_cnt++; if (pc !== model_pc) $display("FAIL pc_inc_wrap: got %h required %h", pc, model_pc); else pass_cnt++;
    drive_pc_load(32'h0000_0040, 1'b1);
    total_cnt++; if (pc !== 32'h40) $display("FAIL pc_load_priority: got %h required 00000040", pc); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (pc !== 32'h40) $display("FAIL pc_hold: got %h required 00000040", pc); else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    drive_pc_load(32'h0000_0300, 1'b0);
    fetch_start = 1'b1;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    imem_gnt = 1'b1;
    @(posedge clk); #1;
    imem_gnt = 1'b0;
    total_cnt++; if (fetch_busy !== 1'b1 || dbg_state !== 2'd2) $display("FAIL wait_entered: got busy=%b state=%0d required 1/2", fetch_busy, dbg_state); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if ({imem_req, fetch_busy, dbg_state} !== 4'b0000 || pc !== 32'h0)
      $display("FAIL async_reset: got req=%b busy=%b state=%0d pc=%h required 0/0/0/0", imem_req, fetch_busy, dbg_state, pc); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_pc = 32'h0; model_ir = NOP_INSTR;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D; imem_err = 1'b0;
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    total_cnt++; if (instr !== model_ir || fetch_done !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL late_rvalid: got %h done=%b state=%0d required %h/0/0", instr, fetch_done, dbg_state, model_ir); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; pc_inc = 1'b0; pc_load_val = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
    model_pc = '0; model_ir = NOP_INSTR;
    @(posedge clk); #1;
    test_reset();
    test_basic_fetch();
    test_gnt_stall();
    test_misaligned();
    test_bus_error();
    test_timeout();
    test_back_to_back();
    test_pc_update();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
